// File: rtl/bcd_display_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_counter_if
// Description : Control, count and 7-segment scan signals of the BCD display
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_counter_if #(
    parameter int DIGITS = 4
);
    logic                  run;
    logic                  down;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic [6:0]            segments;
    logic [DIGITS-1:0]     digit_sel;

    modport master (
        output run, down, load, load_value,
        input  count, wrap, segments, digit_sel
    );

    modport slave (
        input  run, down, load, load_value,
        output count, wrap, segments, digit_sel
    );
endinterface
`default_nettype wire

// File: rtl/bcd_display_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_counter
// Description : Multi-digit BCD up/down counter with prescaler, preset load,
//               wrap pulse and time-multiplexed 7-segment scan output.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_counter #(
    parameter int MAX_COUNT  = 10_000_000,
    parameter int DIGITS     = 4,
    parameter int SCAN_COUNT = 10_000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    bcd_display_counter_if.slave   bus
);

    localparam int c_PRESC_W = (MAX_COUNT > 1)  ? $clog2(MAX_COUNT)  : 1;
    localparam int c_SCAN_W  = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int c_IDX_W   = (DIGITS > 1)     ? $clog2(DIGITS)     : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(MAX_COUNT - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_COUNT - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(DIGITS - 1);
    localparam logic [6:0]           c_SEG_ZERO   = 7'b0111111;

    function automatic logic [6:0] f_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [c_PRESC_W-1:0] r_presc;
    logic [c_PRESC_W-1:0] w_presc_next;
    logic                 w_tick;

    logic [4*DIGITS-1:0]  r_count;
    logic [4*DIGITS-1:0]  w_count_step;
    logic [4*DIGITS-1:0]  w_count_load;
    logic [4*DIGITS-1:0]  w_count_next;
    logic                 w_limit_all;
    logic                 r_wrap;
    logic                 w_wrap_next;

    logic [c_SCAN_W-1:0]  r_scan;
    logic [c_SCAN_W-1:0]  w_scan_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_next;

    logic [DIGITS-1:0]    w_zero_above;
    logic                 w_zero_run;
    logic [3:0]           w_sel_nibble;
    logic                 w_sel_zero_above;
    logic [DIGITS-1:0]    w_sel_next;
    logic [6:0]           w_seg_next;
    logic [DIGITS-1:0]    r_digit_sel;
    logic [6:0]           r_segments;

    assign w_tick = bus.run && (r_presc == c_PRESC_LAST);

    // Ripple step: a digit moves only while every lower digit sits at its limit
    // (9 counting up, 0 counting down); the final limit flag is the wrap case.
    always_comb begin
        w_count_step = r_count;
        w_limit_all  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_limit_all) begin
                if (bus.down) begin
                    w_count_step[4*i +: 4] = (r_count[4*i +: 4] == 4'd0) ? 4'd9
                                           : r_count[4*i +: 4] - 4'd1;
                end else begin
                    w_count_step[4*i +: 4] = (r_count[4*i +: 4] >= 4'd9) ? 4'd0
                                           : r_count[4*i +: 4] + 4'd1;
                end
            end
            w_limit_all = w_limit_all &&
                          (r_count[4*i +: 4] == (bus.down ? 4'd0 : 4'd9));
        end
    end

    always_comb begin
        w_count_load = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_count_load[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd9
                                   : bus.load_value[4*i +: 4];
        end
    end

    // Load beats a coincident tick, so that tick neither steps nor wraps.
    always_comb begin
        w_count_next = r_count;
        w_presc_next = r_presc;
        w_wrap_next  = 1'b0;
        if (bus.load) begin
            w_count_next = w_count_load;
            w_presc_next = '0;
        end else if (w_tick) begin
            w_count_next = w_count_step;
            w_presc_next = '0;
            w_wrap_next  = w_limit_all;
        end else if (bus.run) begin
            w_presc_next = r_presc + 1'b1;
        end
    end

    always_comb begin
        w_scan_next = r_scan + 1'b1;
        w_idx_next  = r_idx;
        if (r_scan == c_SCAN_LAST) begin
            w_scan_next = '0;
            w_idx_next  = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Display registers are fed from next-state values so select and segments
    // always describe the same digit and the same count.
    always_comb begin
        w_zero_above     = '0;
        w_zero_run       = 1'b1;
        w_sel_nibble     = 4'd0;
        w_sel_zero_above = 1'b0;
        w_sel_next       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run && (w_count_next[4*i +: 4] == 4'd0);
            w_zero_above[i] = w_zero_run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_next == c_IDX_W'(i)) begin
                w_sel_nibble     = w_count_next[4*i +: 4];
                w_sel_zero_above = w_zero_above[i];
                w_sel_next[i]    = 1'b1;
            end
        end
        w_seg_next = f_decode(w_sel_nibble);
        if (BLANK_LZ && (w_idx_next != '0) && w_sel_zero_above) begin
            w_seg_next = 7'b0000000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_count     <= '0;
            r_wrap      <= 1'b0;
            r_scan      <= '0;
            r_idx       <= '0;
            r_digit_sel <= DIGITS'(1);
            r_segments  <= c_SEG_ZERO;
        end else begin
            r_presc     <= w_presc_next;
            r_count     <= w_count_next;
            r_wrap      <= w_wrap_next;
            r_scan      <= w_scan_next;
            r_idx       <= w_idx_next;
            r_digit_sel <= w_sel_next;
            r_segments  <= w_seg_next;
        end
    end

    assign bus.count     = r_count;
    assign bus.wrap      = r_wrap;
    assign bus.segments  = r_segments;
    assign bus.digit_sel = r_digit_sel;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_counter
// Description : Directed self-checking bench for bcd_display_counter with
//               MAX_COUNT=4, DIGITS=2, SCAN_COUNT=3, leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_counter;

    localparam int c_MAX_COUNT  = 4;
    localparam int c_DIGITS     = 2;
    localparam int c_SCAN_COUNT = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n_edges = 0;

    logic [6:0] seg_tab [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                   7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
                                   7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    logic [7:0] exp_up [0:10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                  8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

    bcd_display_counter_if #(.DIGITS(c_DIGITS)) bus ();

    bcd_display_counter #(
        .MAX_COUNT  (c_MAX_COUNT),
        .DIGITS     (c_DIGITS),
        .SCAN_COUNT (c_SCAN_COUNT),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Non-reset edges since the last reset: the scan phase follows from it.
    always @(posedge clk) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    function automatic logic [1:0] exp_sel(input int n);
        return (((n / c_SCAN_COUNT) % 2) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [7:0] c, input logic [1:0] sel);
        if (sel == 2'b01)       return seg_tab[c[3:0]];
        else if (c[7:4] == 4'd0) return 7'b0000000;
        else                    return seg_tab[c[7:4]];
    endfunction

    task automatic test_reset();
        reset = 1'b1; bus.run = 1'b0; bus.down = 1'b0;
        bus.load = 1'b0; bus.load_value = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h expected 00", bus.count); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
        checks++; if (bus.digit_sel !== 2'b01) begin errors++; $display("FAIL reset_sel: got %b expected 01", bus.digit_sel); end
        checks++; if (bus.segments !== 7'b0111111) begin errors++; $display("FAIL reset_seg: got %b expected 0111111", bus.segments); end
        reset = 1'b0; bus.run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL first_tick_early: cycle %0d got %h expected 00", k, bus.count); end
        end
        @(negedge clk);
        checks++; if (bus.count !== 8'h01) begin errors++; $display("FAIL first_tick: got %h expected 01", bus.count); end
    endtask

    task automatic test_count_up();
        logic [1:0] sel;
        for (int k = 2; k <= 10; k++) begin
            repeat (3) @(negedge clk);
            checks++; if (bus.count !== exp_up[k-1]) begin errors++; $display("FAIL up_hold: step %0d got %h expected %h", k, bus.count, exp_up[k-1]); end
            @(negedge clk);
            sel = exp_sel(n_edges);
            checks++; if (bus.count !== exp_up[k]) begin errors++; $display("FAIL up_step: step %0d got %h expected %h", k, bus.count, exp_up[k]); end
            checks++; if (bus.digit_sel !== sel) begin errors++; $display("FAIL up_sel: step %0d got %b expected %b", k, bus.digit_sel, sel); end
            checks++; if (bus.segments !== exp_seg(exp_up[k], sel)) begin errors++; $display("FAIL up_seg: step %0d got %b expected %b", k, bus.segments, exp_seg(exp_up[k], sel)); end
        end
    endtask

    task automatic test_wrap_up();
        bus.load = 1'b1; bus.load_value = 8'h98;
        @(negedge clk);
        checks++; if (bus.count !== 8'h98) begin errors++; $display("FAIL load_98: got %h expected 98", bus.count); end
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.count !== 8'h99 || bus.wrap !== 1'b0) begin errors++; $display("FAIL step_99: got %h/%b expected 99/0", bus.count, bus.wrap); end
        repeat (3) @(negedge clk);
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_early: got %b expected 0", bus.wrap); end
        @(negedge clk);
        checks++; if (bus.count !== 8'h00 || bus.wrap !== 1'b1) begin errors++; $display("FAIL wrap_up: got %h/%b expected 00/1", bus.count, bus.wrap); end
        @(negedge clk);
        checks++; if (bus.count !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_pulse: got %h/%b expected 00/0", bus.count, bus.wrap); end
    endtask

    task automatic test_count_down();
        bus.down = 1'b1; bus.load = 1'b1; bus.load_value = 8'h00;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.count !== 8'h99 || bus.wrap !== 1'b1) begin errors++; $display("FAIL wrap_down: got %h/%b expected 99/1", bus.count, bus.wrap); end
        @(negedge clk);
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_down_pulse: got %b expected 0", bus.wrap); end
        bus.load = 1'b1; bus.load_value = 8'h10;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.count !== 8'h09) begin errors++; $display("FAIL borrow: got %h expected 09", bus.count); end
        @(negedge clk);
        bus.down = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.count !== 8'h09) begin errors++; $display("FAIL dir_early: got %h expected 09", bus.count); end
        @(negedge clk);
        checks++; if (bus.count !== 8'h10) begin errors++; $display("FAIL dir_up: got %h expected 10", bus.count); end
        @(negedge clk);
        bus.down = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.count !== 8'h10) begin errors++; $display("FAIL dir_hold: got %h expected 10", bus.count); end
        @(negedge clk);
        checks++; if (bus.count !== 8'h09) begin errors++; $display("FAIL dir_down: got %h expected 09", bus.count); end
    endtask

    task automatic test_pause_load();
        bus.down = 1'b0; bus.load = 1'b1; bus.load_value = 8'h20;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.count !== 8'h21) begin errors++; $display("FAIL pre_pause: got %h expected 21", bus.count); end
        @(negedge clk);
        bus.run = 1'b0;
        repeat (5) @(negedge clk);
        bus.run = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.count !== 8'h21) begin errors++; $display("FAIL pause_early: got %h expected 21", bus.count); end
        @(negedge clk);
        checks++; if (bus.count !== 8'h22) begin errors++; $display("FAIL pause_tick: got %h expected 22", bus.count); end
        repeat (4) @(negedge clk);
        checks++; if (bus.count !== 8'h23) begin errors++; $display("FAIL post_pause: got %h expected 23", bus.count); end
        bus.load = 1'b1; bus.load_value = 8'hFA;
        @(negedge clk);
        checks++; if (bus.count !== 8'h99) begin errors++; $display("FAIL load_clamp: got %h expected 99", bus.count); end
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.count !== 8'h99) begin errors++; $display("FAIL load_presc_clear: got %h expected 99", bus.count); end
        bus.load = 1'b1; bus.load_value = 8'h45;
        @(negedge clk);
        checks++; if (bus.count !== 8'h45 || bus.wrap !== 1'b0) begin errors++; $display("FAIL load_on_tick: got %h/%b expected 45/0", bus.count, bus.wrap); end
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.count !== 8'h45) begin errors++; $display("FAIL after_load_hold: got %h expected 45", bus.count); end
        @(negedge clk);
        checks++; if (bus.count !== 8'h46) begin errors++; $display("FAIL after_load_tick: got %h expected 46", bus.count); end
    endtask

    task automatic test_blanking();
        logic [1:0] sel;
        logic [1:0] prev_sel;
        int         run_len;
        int         changes;
        bus.run = 1'b0; bus.load = 1'b1; bus.load_value = 8'h05;
        @(negedge clk);
        bus.load = 1'b0;
        prev_sel = bus.digit_sel;
        run_len  = 1;
        changes  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sel = exp_sel(n_edges);
            checks++; if (bus.digit_sel !== sel) begin errors++; $display("FAIL blank_sel: cycle %0d got %b expected %b", k, bus.digit_sel, sel); end
            if (sel == 2'b01) begin
                checks++; if (bus.segments !== 7'b1101101) begin errors++; $display("FAIL blank_d0: cycle %0d got %b expected 1101101", k, bus.segments); end
            end else begin
                checks++; if (bus.segments !== 7'b0000000) begin errors++; $display("FAIL blank_d1: cycle %0d got %b expected 0000000", k, bus.segments); end
            end
            if (bus.digit_sel === prev_sel) begin
                run_len++;
            end else begin
                if (changes > 0) begin
                    checks++; if (run_len !== c_SCAN_COUNT) begin errors++; $display("FAIL scan_dwell: got %0d expected %0d", run_len, c_SCAN_COUNT); end
                end
                changes++;
                run_len  = 1;
                prev_sel = bus.digit_sel;
            end
        end
        checks++; if (bus.count !== 8'h05) begin errors++; $display("FAIL blank_count: got %h expected 05", bus.count); end
    endtask

    task automatic test_reset_mid();
        bus.run = 1'b1; bus.load = 1'b1; bus.load_value = 8'h37;
        @(negedge clk);
        bus.load = 1'b0; bus.run = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.count !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL mid_reset_count: got %h/%b expected 00/0", bus.count, bus.wrap); end
        checks++; if (bus.digit_sel !== 2'b01 || bus.segments !== 7'b0111111) begin errors++; $display("FAIL mid_reset_disp: got %b/%b expected 01/0111111", bus.digit_sel, bus.segments); end
        reset = 1'b0; bus.load = 1'b1; bus.load_value = 8'h37;
        @(negedge clk);
        bus.load = 1'b0;
        checks++; if (bus.count !== 8'h37) begin errors++; $display("FAIL reload_37: got %h expected 37", bus.count); end
        repeat (2) @(negedge clk);
        reset = 1'b1; bus.load = 1'b1; bus.load_value = 8'h37;
        @(negedge clk);
        checks++; if (bus.count !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_over_load: got %h/%b expected 00/0", bus.count, bus.wrap); end
        checks++; if (bus.digit_sel !== 2'b01 || bus.segments !== 7'b0111111) begin errors++; $display("FAIL reset_over_load_disp: got %b/%b expected 01/0111111", bus.digit_sel, bus.segments); end
        reset = 1'b0; bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_pause_load();
        test_blanking();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
